ase_axis_tlp_tx_framer: RTL and testbench
=========================================

// Module: ase_axis_tlp_tx_framer
// PURPOSE
// Capture stage on the AFU->host AXI-S PCIe TLP channel, upstream of the DPI-C layer that consumes
// t_ase_axis_pcie_tdata records. Accepts AFU beats under tvalid/tready and checks SOP/EOP framing.
// Checks the beat count against the DW0 length field, then buffers beats in a FIFO.
// The simulator side pops them one per cycle. Sticky error flags and a packet counter support debug.
// PARAMETERS
// FIFO_DEPTH   16   beat entries; power of 2, >=2
// PAYLOAD_W    256  payload bits per beat (channel_payload_bytes*8)
// HDR_W        128  TLP header bits; hdr[31:0]=DW0 (fmt[31:29], type[28:24], length[9:0])
// PORTS
// clk               in   1          clock
// reset             in   1          asynchronous, active-high reset
// afu_tx_tvalid     in   1          AFU beat valid
// afu_tx_tready     out  1          framer can accept a beat
// afu_tx_sop        in   1          start of packet
// afu_tx_eop        in   1          end of packet
// afu_tx_hdr        in   HDR_W      header; meaningful on SOP beats only
// afu_tx_payload    in   PAYLOAD_W  payload
// afu_tx_afu_irq    in   1          tuser.afu_irq
// host_tx_valid     out  1          FIFO head valid
// host_tx_deq       in   1          pop head; ignored when host_tx_valid=0
// host_tx_sop/eop   out  1 each     head sop/eop
// host_tx_hdr       out  HDR_W      head header
// host_tx_payload   out  PAYLOAD_W  head payload
// host_tx_afu_irq   out  1          head afu_irq
// err_sop_in_pkt    out  1          sticky: SOP while already inside a packet
// err_orphan        out  1          sticky: non-SOP beat outside a packet (beat dropped)
// err_len           out  1          sticky: data beat count != expected from DW0 length
// pkt_count         out  32         packets enqueued (EOP beats written); wraps 2^32-1 -> 0
// BEHAVIOUR
// - Reset values: all outputs 0. FIFO empty, state IDLE, beat counter 0. tready=0 while reset is high, 1 the first cycle after release.
// - Accept = tvalid & tready. tready = (occupancy < FIFO_DEPTH), combinational on occupancy, not on host_tx_deq.
// - No full-FIFO bypass: when full, a same-cycle deq does not raise tready until the next cycle.
// - Latency: beat accepted in cycle N appears at the FIFO head no earlier than N+1. FIFO order is strict.
// - host_tx_valid = occupancy != 0. The head fields are stable while valid & !deq.
// - Simultaneous enqueue and dequeue leave occupancy unchanged.
// - Pointers wrap modulo FIFO_DEPTH. Occupancy is kept in clog2(FIFO_DEPTH)+1 bits.
// - FSM IDLE: accepted beat with sop=1 -> enqueue, latch expected beats, count=1; eop=1 -> IDLE, else -> IN_PKT.
// - FSM IDLE: accepted beat with sop=0 -> drop (not enqueued), set err_orphan, stay IDLE (eop is ignored).
// - FSM IN_PKT: sop=0 -> enqueue, count+1; eop=1 -> compare, then IDLE.
// - FSM IN_PKT: sop=1 -> set err_sop_in_pkt, enqueue, restart as a new packet (relatch, count=1).
// - Expected beats: no-data TLP (fmt[30]=0) = 1. Data TLP: len_dw = length==0 ? 1024 : length.
// - Data TLP beats = 1 + ceil(len_dw*4 / (PAYLOAD_W/8)), since the header travels on its own SOP beat with an unused payload.
// - Compute expected beats in 11-bit arithmetic to avoid truncation.
// - On EOP, if count != expected, set err_len. The beat is still enqueued; the packet is not altered.
// - Counter saturation: beat counter saturates at 2^11-1. A packet reaching saturation sets err_len at EOP.
// - pkt_count increments on every enqueued EOP beat, including packets flagged by err_len or err_sop_in_pkt.
// - Sticky flags clear only on reset.
// - Reset asserted mid-packet: FIFO flushed, FSM -> IDLE, flags and pkt_count cleared. No partial-packet recovery.
// TESTING
// - Write, len=16DW, PAYLOAD_W=256, hdr DW0=0x4000_0010: SOP beat + 2 data beats, EOP on 3rd
//   -> 3 beats out in order, pkt_count=1, no errors.
// - Read request DW0=0x0000_0004, sop=eop=1 -> 1 beat out, pkt_count=1, err_len=0.
// - Fill with host_tx_deq=0: tready drops after 16 accepts. Assert deq for 1 cycle
//   -> tready=1 the next cycle, occupancy 15->16, head order preserved.
// - Beat sop=0 in IDLE -> not enqueued, err_orphan=1. A second SOP mid-packet -> err_sop_in_pkt=1,
//   both SOPs visible at the output.
// - Write DW0 length=0 (1024DW) with only 5 beats -> err_len=1 at EOP, pkt_count=1.
// - Reset pulse with 7 entries buffered mid-packet -> host_tx_valid=0 and all flags 0 during reset.
//   The next clean packet is accepted normally.

Source files
------------

// File: rtl/ase_axis_tlp_tx_framer.sv
// ase_axis_tlp_tx_framer
// AFU->host AXI-S TLP capture stage: checks SOP/EOP framing and the beat
// count against the DW0 length, then buffers beats for the simulator side.
module ase_axis_tlp_tx_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PAYLOAD_W  = 256,
  parameter int HDR_W      = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 afu_tx_tvalid,
  output logic                 afu_tx_tready,
  input  logic                 afu_tx_sop,
  input  logic                 afu_tx_eop,
  input  logic [HDR_W-1:0]     afu_tx_hdr,
  input  logic [PAYLOAD_W-1:0] afu_tx_payload,
  input  logic                 afu_tx_afu_irq,
  output logic                 host_tx_valid,
  input  logic                 host_tx_deq,
  output logic                 host_tx_sop,
  output logic                 host_tx_eop,
  output logic [HDR_W-1:0]     host_tx_hdr,
  output logic [PAYLOAD_W-1:0] host_tx_payload,
  output logic                 host_tx_afu_irq,
  output logic                 err_sop_in_pkt,
  output logic                 err_orphan,
  output logic                 err_len,
  output logic [31:0]          pkt_count
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int OW          = AW + 1;
  localparam int EW          = 3 + HDR_W + PAYLOAD_W;
  localparam int DW_PER_BEAT = PAYLOAD_W / 32;

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } state_t;

  // Expected beat count; dividing DWs by DWs-per-beat keeps everything
  // inside 11 bits (max 1024 + DW_PER_BEAT - 1).
  function automatic logic [10:0] calc_exp(input logic fmt_data, input logic [9:0] len);
    logic [10:0] len_dw;
    len_dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    if (!fmt_data) return 11'd1;
    return 11'd1 + (len_dw + 11'(DW_PER_BEAT - 1)) / 11'(DW_PER_BEAT);
  endfunction

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] exp_q, exp_d;
  logic        err_sip_q, err_sip_d;
  logic        err_orph_q, err_orph_d;
  logic        err_len_q, err_len_d;
  logic [31:0] pkt_q, pkt_d;

  logic          accept, enq, deq;
  logic [EW-1:0] head;

  assign afu_tx_tready = !reset && (occ_q < OW'(FIFO_DEPTH));
  assign accept        = afu_tx_tvalid && afu_tx_tready;
  assign enq           = accept && (afu_tx_sop || state_q == S_IN_PKT);
  assign host_tx_valid = (occ_q != '0);
  assign deq           = host_tx_deq && host_tx_valid;

  assign head = host_tx_valid ? mem[rd_ptr_q] : '0;
  assign {host_tx_sop, host_tx_eop, host_tx_afu_irq, host_tx_hdr, host_tx_payload} = head;

  assign err_sop_in_pkt = err_sip_q;
  assign err_orphan     = err_orph_q;
  assign err_len        = err_len_q;
  assign pkt_count      = pkt_q;

  // FIFO storage: data array is not reset, validity comes from occupancy
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr_q] <= {afu_tx_sop, afu_tx_eop, afu_tx_afu_irq, afu_tx_hdr, afu_tx_payload};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Framing FSM next state: beat counting, length check, sticky errors
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    err_sip_d  = err_sip_q;
    err_orph_d = err_orph_q;
    err_len_d  = err_len_q;
    pkt_d      = pkt_q;
    if (accept) begin
      if (!afu_tx_sop && state_q == S_IDLE) begin
        err_orph_d = 1'b1;
      end else begin
        if (afu_tx_sop) begin
          if (state_q == S_IN_PKT) err_sip_d = 1'b1;
          exp_d = calc_exp(afu_tx_hdr[30], afu_tx_hdr[9:0]);
          cnt_d = 11'd1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 11'd1;
        end
        if (afu_tx_eop) begin
          if (cnt_d != exp_d) err_len_d = 1'b1;
          pkt_d   = pkt_q + 32'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_IN_PKT;
        end
      end
    end
  end

  // Framing FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      exp_q      <= '0;
      err_sip_q  <= 1'b0;
      err_orph_q <= 1'b0;
      err_len_q  <= 1'b0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      err_sip_q  <= err_sip_d;
      err_orph_q <= err_orph_d;
      err_len_q  <= err_len_d;
      pkt_q      <= pkt_d;
    end
  end

endmodule

// File: tb/tb_ase_axis_tlp_tx_framer.sv
// Bench for ase_axis_tlp_tx_framer: directed framing cases plus random
// packets, checked through an expected-beat queue drained by a monitor.
module tb_ase_axis_tlp_tx_framer;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic         irq;
    logic [127:0] hdr;
    logic [255:0] pay;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         afu_tx_tvalid = 1'b0;
  logic         afu_tx_tready;
  logic         afu_tx_sop = 1'b0;
  logic         afu_tx_eop = 1'b0;
  logic [127:0] afu_tx_hdr = '0;
  logic [255:0] afu_tx_payload = '0;
  logic         afu_tx_afu_irq = 1'b0;
  logic         host_tx_valid;
  logic         host_tx_deq = 1'b0;
  logic         host_tx_sop, host_tx_eop, host_tx_afu_irq;
  logic [127:0] host_tx_hdr;
  logic [255:0] host_tx_payload;
  logic         err_sop_in_pkt, err_orphan, err_len;
  logic [31:0]  pkt_count;

  ase_axis_tlp_tx_framer #(.FIFO_DEPTH(16), .PAYLOAD_W(256), .HDR_W(128)) dut (
    .clk(clk), .reset(reset),
    .afu_tx_tvalid(afu_tx_tvalid), .afu_tx_tready(afu_tx_tready),
    .afu_tx_sop(afu_tx_sop), .afu_tx_eop(afu_tx_eop),
    .afu_tx_hdr(afu_tx_hdr), .afu_tx_payload(afu_tx_payload),
    .afu_tx_afu_irq(afu_tx_afu_irq),
    .host_tx_valid(host_tx_valid), .host_tx_deq(host_tx_deq),
    .host_tx_sop(host_tx_sop), .host_tx_eop(host_tx_eop),
    .host_tx_hdr(host_tx_hdr), .host_tx_payload(host_tx_payload),
    .host_tx_afu_irq(host_tx_afu_irq),
    .err_sop_in_pkt(err_sop_in_pkt), .err_orphan(err_orphan),
    .err_len(err_len), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  beat_t       sb[$];
  beat_t       pend;
  bit          pend_v = 0;
  bit          m_in = 0;
  int          m_cnt = 0;
  int          m_exp = 0;
  bit          m_orph = 0, m_sip = 0, m_len = 0;
  int unsigned m_pkt = 0;

  int deq_prob = 0;
  bit force_once = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Header beat plus ceil(payload bytes / 32-byte beat) data beats
  function automatic int exp_beats(input logic [127:0] h);
    int len;
    if (!h[30]) return 1;
    len = (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
    return 1 + (len * 4 + 31) / 32;
  endfunction

  task automatic model_clear();
    sb.delete();
    pend_v = 0; m_in = 0; m_cnt = 0; m_exp = 0;
    m_orph = 0; m_sip = 0; m_len = 0; m_pkt = 0;
  endtask

  task automatic model_apply(input beat_t b);
    if (!m_in && !b.sop) begin
      m_orph = 1;
      return;
    end
    if (b.sop) begin
      if (m_in) m_sip = 1;
      m_exp = exp_beats(b.hdr);
      m_cnt = 1;
    end else if (m_cnt < 2047) begin
      m_cnt++;
    end
    pend = b;
    pend_v = 1;
    if (b.eop) begin
      if (m_cnt != m_exp) m_len = 1;
      m_pkt++;
      m_in = 0;
    end else begin
      m_in = 1;
    end
  endtask

  function automatic beat_t rand_beat(input logic sop, input logic eop, input logic [31:0] dw0);
    beat_t b;
    b.sop = sop;
    b.eop = eop;
    b.irq = 1'($urandom);
    b.hdr = {$urandom, $urandom, $urandom, dw0};
    b.pay = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  // One clock of stimulus: drive at negedge, check handshake and flags,
  // feed the model, commit the expected beat after the active edge.
  task automatic drive_cycle(input logic rst, input logic v, input beat_t b, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    reset = rst;
    afu_tx_tvalid = v;
    afu_tx_sop = b.sop;
    afu_tx_eop = b.eop;
    afu_tx_afu_irq = b.irq;
    afu_tx_hdr = b.hdr;
    afu_tx_payload = b.pay;
    if (rst) model_clear();
    #1;
    exp_rdy = !rst && (sb.size() < 16);
    chk("tready", 512'(afu_tx_tready), 512'(exp_rdy));
    chk("err_orphan", 512'(err_orphan), 512'(m_orph));
    chk("err_sop_in_pkt", 512'(err_sop_in_pkt), 512'(m_sip));
    chk("err_len", 512'(err_len), 512'(m_len));
    chk("pkt_count", 512'(pkt_count), 512'(m_pkt));
    acc = v && exp_rdy;
    if (acc) model_apply(b);
    @(posedge clk);
    #1;
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, rand_beat(1'b0, 1'b0, 32'h0), acc);
  endtask

  task automatic send_beat(input beat_t b);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 400) begin
      drive_cycle(1'b0, ($urandom_range(0, 3) != 0), b, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept after %0d cycles, expected accept", n);
    end
  endtask

  task automatic send_pkt(input logic [31:0] dw0, input int nbeats, input bit with_eop);
    for (int i = 0; i < nbeats; i++)
      send_beat(rand_beat(i == 0, with_eop && (i == nbeats - 1), dw0));
  endtask

  task automatic drain();
    int n = 0;
    deq_prob = 100;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats left, expected 0", sb.size());
    end
  endtask

  // Monitor: drive dequeue, compare head against the expected queue
  initial begin
    logic  d;
    bit    ev;
    beat_t h;
    forever begin
      @(negedge clk);
      d = force_once || ($urandom_range(0, 99) < deq_prob);
      force_once = 0;
      host_tx_deq = d;
      #2;
      ev = (sb.size() != 0);
      chk("host_tx_valid", 512'(host_tx_valid), 512'(ev));
      if (ev) begin
        h = sb[0];
        chk("head", 512'({host_tx_sop, host_tx_eop, host_tx_afu_irq, host_tx_hdr, host_tx_payload}), 512'(h));
        if (d) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic  acc;
    beat_t b;
    int    nb;
    logic [31:0] dw0;

    // Reset state: tready low, outputs cleared
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, rand_beat(1'b1, 1'b1, 32'h0), acc);
    deq_prob = 100;

    // Write 16 DW: header beat + 2 data beats
    send_pkt(32'h4000_0010, 3, 1);
    idle(4);
    // Read request, single beat
    send_pkt(32'h0000_0004, 1, 1);
    idle(4);

    // Orphan beat, then a second SOP inside a packet
    send_beat(rand_beat(1'b0, 1'b1, 32'h0));
    send_pkt(32'h4000_0010, 2, 0);
    send_pkt(32'h4000_0010, 3, 1);
    idle(4);

    // Length 0 means 1024 DW: 5 beats is short
    send_pkt(32'h4000_0000, 5, 1);
    drain();

    // Fill without dequeue, then a single dequeue reopens one slot
    deq_prob = 0;
    send_pkt(32'h4000_0000, 16, 0);
    b = rand_beat(1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, b, acc);
    drive_cycle(1'b0, 1'b1, b, acc);
    force_once = 1;
    drive_cycle(1'b0, 1'b1, b, acc);
    send_beat(b);
    idle(3);
    drain();

    // Reset with 7 beats buffered mid-packet
    deq_prob = 0;
    for (int i = 0; i < 7; i++) send_beat(rand_beat(1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b0, rand_beat(1'b0, 1'b0, 32'h0), acc);
    deq_prob = 100;
    send_pkt(32'h4000_0010, 3, 1);
    drain();

    // Random packets
    for (int p = 0; p < 80; p++) begin
      deq_prob = $urandom_range(20, 100);
      if ($urandom_range(0, 9) == 0) send_beat(rand_beat(1'b0, 1'($urandom), 32'h0));
      dw0 = $urandom;
      dw0[9:0] = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 64));
      if (dw0[9:0] == 10'd0) dw0[30] = 1'b0;
      nb = exp_beats({96'h0, dw0});
      case ($urandom_range(0, 9))
        0: nb = nb + 1;
        1: if (nb > 1) nb = nb - 1;
        default: ;
      endcase
      send_pkt(dw0, nb, ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
